// File: rtl/mpu_hm_pkg.sv
// Shared constants for the MPU host-memory responder: FSM encoding,
// Wishbone constants and the byte-reverse helper.
package mpu_hm_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] ST_ACK  = 2'd3;

  localparam logic [63:0] HM_ERR_DATA    = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [3:0]  WB_SEL_ALL     = 4'hF;
  localparam logic [2:0]  WB_CTI_CLASSIC = 3'b000;

  // Reverse byte order across a 64-bit word (big-endian view).
  function automatic logic [63:0] bswap64(input logic [63:0] d);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) begin
      r[8*i +: 8] = d[8*(7-i) +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mpu_hm_timeout.sv
// Per-word Wishbone response timer; expired is high on the last allowed cycle.
module mpu_hm_timeout #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned TW      = 9
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + TW'(1);
    end
  end

  assign expired = (cnt_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/mpu_host_memory.sv
// MPU host-memory responder: one 64-bit read as two 32-bit Wishbone classic reads.
// Optional macro MPU_HM_BSWAP_EN returns the word byte-reversed (big-endian view).
module mpu_host_memory
  import mpu_hm_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned TW      = 9
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [63:0] hm_addr,
  input  logic        hm_start,
  output logic [63:0] hm_data,
  output logic        hm_ack,
  output logic        hm_error,
  output logic        busy,
  output logic [31:0] wb_adr_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [2:0]  wb_cti_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  logic [1:0]  state_q, state_d;
  logic        start_q;
  logic [28:0] a_q, a_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] adr_d;
  logic        cyc_d;
  logic [63:0] data_d;
  logic        ack_d, err_d, busy_d;
  logic        tmr_clr_c, tmr_en_c, expired_c;
  logic        req_c;
  logic        unused_addr_bits;

  assign req_c            = hm_start & ~start_q;
  assign unused_addr_bits = ^hm_addr[2:0];

  assign wb_sel_o = WB_SEL_ALL;
  assign wb_we_o  = 1'b0;
  assign wb_cti_o = WB_CTI_CLASSIC;
  assign wb_stb_o = wb_cyc_o;

  mpu_hm_timeout #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_timeout (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clr     (tmr_clr_c),
    .en      (tmr_en_c),
    .expired (expired_c)
  );

  // Assemble a completed result in the configured byte order.
  function automatic logic [63:0] fmt_result(input logic [63:0] d);
`ifdef MPU_HM_BSWAP_EN
    return bswap64(d);
`else
    return d;
`endif
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    lo_d      = lo_q;
    adr_d     = wb_adr_o;
    cyc_d     = wb_cyc_o;
    data_d    = hm_data;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    busy_d    = busy;
    tmr_clr_c = 1'b0;
    tmr_en_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tmr_clr_c = 1'b1;
        if (req_c) begin
          a_d    = hm_addr[31:3];
          busy_d = 1'b1;
          if (hm_addr[63:32] != 32'd0) begin
            state_d = ST_ACK;
            ack_d   = 1'b1;
            err_d   = 1'b1;
            data_d  = HM_ERR_DATA;
          end else begin
            state_d = ST_LO;
            adr_d   = {hm_addr[31:3], 3'b000};
            cyc_d   = 1'b1;
          end
        end
      end

      ST_LO, ST_HI: begin
        // err wins over a simultaneous ack
        if (wb_err_i || (expired_c && !wb_ack_i)) begin
          state_d   = ST_ACK;
          cyc_d     = 1'b0;
          ack_d     = 1'b1;
          err_d     = 1'b1;
          data_d    = HM_ERR_DATA;
          tmr_clr_c = 1'b1;
        end else if (wb_ack_i) begin
          tmr_clr_c = 1'b1;
          if (state_q == ST_LO) begin
            state_d = ST_HI;
            lo_d    = wb_dat_i;
            adr_d   = {a_q, 3'b100};
          end else begin
            state_d = ST_ACK;
            cyc_d   = 1'b0;
            ack_d   = 1'b1;
            data_d  = fmt_result({wb_dat_i, lo_q});
          end
        end else begin
          tmr_en_c = 1'b1;
        end
      end

      ST_ACK: begin
        state_d   = ST_IDLE;
        busy_d    = 1'b0;
        tmr_clr_c = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= ST_IDLE;
      start_q  <= 1'b0;
      a_q      <= '0;
      lo_q     <= '0;
      wb_adr_o <= '0;
      wb_cyc_o <= 1'b0;
      hm_data  <= '0;
      hm_ack   <= 1'b0;
      hm_error <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= hm_start;
      a_q      <= a_d;
      lo_q     <= lo_d;
      wb_adr_o <= adr_d;
      wb_cyc_o <= cyc_d;
      hm_data  <= data_d;
      hm_ack   <= ack_d;
      hm_error <= err_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_mpu_host_memory.sv
// Directed bench for mpu_host_memory with a registered Wishbone slave model.
module tb_mpu_host_memory;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [63:0] hm_addr;
  logic        hm_start;
  logic [63:0] hm_data;
  logic        hm_ack, hm_error, busy;
  logic [31:0] wb_adr_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [2:0]  wb_cti_o;
  logic        wb_ack_i, wb_err_i;

  int tests  = 0;
  int errors = 0;

  // 0: ack every word, 1: never ack A+4, 2: error on A
  int slave_mode = 0;

  int          ack_total    = 0;
  int          stb_hi_total = 0;
  logic [31:0] adr_log[$];
  logic        prev_stb = 1'b0;
  logic [31:0] prev_adr = 32'd0;

  always #5 sys_clk = ~sys_clk;

  mpu_host_memory #(.TIMEOUT(16), .TW(5)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .hm_addr  (hm_addr),
    .hm_start (hm_start),
    .hm_data  (hm_data),
    .hm_ack   (hm_ack),
    .hm_error (hm_error),
    .busy     (busy),
    .wb_adr_o (wb_adr_o),
    .wb_dat_i (wb_dat_i),
    .wb_sel_o (wb_sel_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_cti_o (wb_cti_o),
    .wb_ack_i (wb_ack_i),
    .wb_err_i (wb_err_i)
  );

  // Byte at address a holds a[7:0]; words are little-endian.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  // Registered slave: responds one cycle after seeing stb.
  always @(posedge sys_clk) begin
    if (!wb_cyc_o || !wb_stb_o || wb_ack_i || wb_err_i) begin
      wb_ack_i <= 1'b0;
      wb_err_i <= 1'b0;
    end else if (slave_mode == 2 && !wb_adr_o[2]) begin
      wb_err_i <= 1'b1;
    end else if (!(slave_mode == 1 && wb_adr_o[2])) begin
      wb_ack_i <= 1'b1;
      wb_dat_i <= mem_word(wb_adr_o);
    end
  end

  // Bus and completion monitor.
  always @(posedge sys_clk) begin
    if (hm_ack) ack_total++;
    if (wb_stb_o && wb_adr_o[2]) stb_hi_total++;
    if (wb_stb_o && (!prev_stb || wb_adr_o != prev_adr)) adr_log.push_back(wb_adr_o);
    prev_stb = wb_stb_o;
    prev_adr = wb_adr_o;
  end

  task automatic start_pulse(input logic [63:0] a);
    hm_addr  = a;
    hm_start = 1'b1;
    @(posedge sys_clk); #1;
    hm_start = 1'b0;
  endtask

  // Called in cycle T+1; lat is the cycle offset of hm_ack from T, -1 if none.
  task automatic wait_ack(output int lat, output logic [63:0] d, output logic e);
    int n;
    n = 1;
    while (!hm_ack && n < 200) begin
      @(posedge sys_clk); #1;
      n++;
    end
    lat = hm_ack ? n : -1;
    d   = hm_data;
    e   = hm_error;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk); #1;
    end
  endtask

  task automatic test_reset;
    int lat; logic [63:0] d; logic e;
    sys_rst  = 1'b1;
    hm_start = 1'b1;
    hm_addr  = 64'h3010;
    idle(3);
    tests++; if (hm_data !== 64'd0) begin errors++; $display("FAIL rst_data got %h want 0", hm_data); end
    tests++; if (hm_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b want 0", hm_ack); end
    tests++; if (hm_error !== 1'b0) begin errors++; $display("FAIL rst_error got %b want 0", hm_error); end
    tests++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    tests++; if ({wb_cyc_o, wb_stb_o} !== 2'b00) begin errors++; $display("FAIL rst_cyc_stb got %b want 00", {wb_cyc_o, wb_stb_o}); end
    tests++; if (wb_adr_o !== 32'd0) begin errors++; $display("FAIL rst_adr got %h want 0", wb_adr_o); end
    tests++; if ({wb_sel_o, wb_we_o, wb_cti_o} !== 8'hF0) begin errors++; $display("FAIL wb_consts got %h want f0", {wb_sel_o, wb_we_o, wb_cti_o}); end
    // start held through reset counts as a request on the first edge after
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;
    hm_start = 1'b0;
    wait_ack(lat, d, e);
    tests++; if (lat !== 5) begin errors++; $display("FAIL rst_held_start_lat got %0d want 5", lat); end
    tests++; if (e !== 1'b0) begin errors++; $display("FAIL rst_held_start_err got %b want 0", e); end
    idle(2);
  endtask

  task automatic test_basic_read;
    int lat; int base; logic [63:0] d; logic e; logic [63:0] exp;
`ifdef MPU_HM_BSWAP_EN
    exp = 64'h0001020304050607;
`else
    exp = 64'h0706050403020100;
`endif
    slave_mode = 0;
    base = adr_log.size();
    start_pulse(64'h1005);
    tests++; if (!(wb_stb_o === 1'b1 && busy === 1'b1)) begin errors++; $display("FAIL basic_stb_t1 got stb=%b busy=%b want 1 1", wb_stb_o, busy); end
    wait_ack(lat, d, e);
    tests++; if (lat !== 5) begin errors++; $display("FAIL basic_lat got %0d want 5", lat); end
    tests++; if (d !== exp) begin errors++; $display("FAIL basic_data got %h want %h", d, exp); end
    tests++; if (e !== 1'b0) begin errors++; $display("FAIL basic_err got %b want 0", e); end
    tests++; if (adr_log.size() - base !== 2) begin errors++; $display("FAIL basic_nacc got %0d want 2", adr_log.size() - base); end
    else begin
      tests++; if (adr_log[base] !== 32'h1000) begin errors++; $display("FAIL basic_adr0 got %h want 1000", adr_log[base]); end
      tests++; if (adr_log[base+1] !== 32'h1004) begin errors++; $display("FAIL basic_adr1 got %h want 1004", adr_log[base+1]); end
    end
    @(posedge sys_clk); #1;
    tests++; if ({hm_ack, busy} !== 2'b00) begin errors++; $display("FAIL basic_after got ack,busy=%b want 00", {hm_ack, busy}); end
    tests++; if (hm_data !== exp) begin errors++; $display("FAIL basic_hold got %h want %h", hm_data, exp); end
  endtask

  task automatic test_high_addr;
    int lat; int base; logic [63:0] d; logic e;
    base = adr_log.size();
    start_pulse(64'h1_0000_0000);
    wait_ack(lat, d, e);
    tests++; if (lat !== 1) begin errors++; $display("FAIL hiaddr_lat got %0d want 1", lat); end
    tests++; if (e !== 1'b1) begin errors++; $display("FAIL hiaddr_err got %b want 1", e); end
    tests++; if (d !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL hiaddr_data got %h want all ones", d); end
    idle(2);
    tests++; if (adr_log.size() !== base) begin errors++; $display("FAIL hiaddr_nobus got %0d accesses want 0", adr_log.size() - base); end
  endtask

  task automatic test_timeout;
    int lat; int base; logic [63:0] d; logic e;
    slave_mode = 1;
    base = stb_hi_total;
    start_pulse(64'h2000);
    wait_ack(lat, d, e);
    tests++; if (lat !== 19) begin errors++; $display("FAIL tmo_lat got %0d want 19", lat); end
    tests++; if (stb_hi_total - base !== 16) begin errors++; $display("FAIL tmo_stb_cycles got %0d want 16", stb_hi_total - base); end
    tests++; if (wb_stb_o !== 1'b0) begin errors++; $display("FAIL tmo_stb_drop got %b want 0", wb_stb_o); end
    tests++; if (e !== 1'b1 || d !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL tmo_err got err=%b data=%h want 1 all ones", e, d); end
    slave_mode = 0;
    idle(2);
  endtask

  task automatic test_bus_error;
    int lat; int base; logic [63:0] d; logic e;
    slave_mode = 2;
    base = adr_log.size();
    start_pulse(64'h1000);
    wait_ack(lat, d, e);
    tests++; if (lat !== 3) begin errors++; $display("FAIL buserr_lat got %0d want 3", lat); end
    tests++; if (e !== 1'b1) begin errors++; $display("FAIL buserr_err got %b want 1", e); end
    tests++; if (wb_cyc_o !== 1'b0) begin errors++; $display("FAIL buserr_cyc got %b want 0", wb_cyc_o); end
    slave_mode = 0;
    idle(3);
    tests++; if (adr_log.size() - base !== 1) begin errors++; $display("FAIL buserr_nacc got %0d want 1", adr_log.size() - base); end
  endtask

  task automatic test_back_to_back;
    int lat; int base_ack; int base_adr; logic [63:0] d; logic e;
    slave_mode = 0;
    // held high: one transfer only
    base_ack = ack_total;
    hm_addr  = 64'h3010;
    hm_start = 1'b1;
    @(posedge sys_clk); #1;
    wait_ack(lat, d, e);
    idle(12);
    tests++; if (ack_total - base_ack !== 1) begin errors++; $display("FAIL held_count got %0d want 1", ack_total - base_ack); end
    tests++; if (d !== 64'h1716151413121110 && d !== 64'h1011121314151617) begin errors++; $display("FAIL held_data got %h", d); end
    hm_start = 1'b0;
    idle(2);
    // second edge while busy is dropped, edge after ACK is served
    base_ack = ack_total;
    base_adr = adr_log.size();
    start_pulse(64'h1000);
    @(posedge sys_clk); #1;
    hm_start = 1'b1;
    @(posedge sys_clk); #1;
    hm_start = 1'b0;
    wait_ack(lat, d, e);
    tests++; if (lat !== 3) begin errors++; $display("FAIL busy_edge_lat got %0d want 3", lat); end
    @(posedge sys_clk); #1;
    start_pulse(64'h3010);
    wait_ack(lat, d, e);
    tests++; if (lat !== 5) begin errors++; $display("FAIL after_ack_lat got %0d want 5", lat); end
    idle(10);
    tests++; if (ack_total - base_ack !== 2) begin errors++; $display("FAIL b2b_count got %0d want 2", ack_total - base_ack); end
    tests++; if (adr_log.size() - base_adr !== 4) begin errors++; $display("FAIL b2b_nacc got %0d want 4", adr_log.size() - base_adr); end
  endtask

  task automatic test_reset_in_hi;
    int lat; int n; int base_ack; logic [63:0] d; logic e; logic [63:0] exp;
`ifdef MPU_HM_BSWAP_EN
    exp = 64'h1011121314151617;
`else
    exp = 64'h1716151413121110;
`endif
    slave_mode = 1;
    start_pulse(64'h1000);
    n = 0;
    while (!(wb_stb_o && wb_adr_o == 32'h1004) && n < 20) begin
      @(posedge sys_clk); #1;
      n++;
    end
    tests++; if (!(wb_stb_o === 1'b1 && wb_adr_o === 32'h1004)) begin errors++; $display("FAIL rsthi_reach got adr=%h stb=%b want 1004 1", wb_adr_o, wb_stb_o); end
    base_ack = ack_total;
    sys_rst  = 1'b1;
    @(posedge sys_clk); #1;
    sys_rst  = 1'b0;
    tests++; if ({wb_cyc_o, wb_stb_o, busy, hm_ack} !== 4'b0000) begin errors++; $display("FAIL rsthi_ctl got cyc,stb,busy,ack=%b want 0000", {wb_cyc_o, wb_stb_o, busy, hm_ack}); end
    tests++; if (hm_data !== 64'd0) begin errors++; $display("FAIL rsthi_data got %h want 0", hm_data); end
    idle(20);
    tests++; if (ack_total !== base_ack) begin errors++; $display("FAIL rsthi_noack got %0d acks want 0", ack_total - base_ack); end
    slave_mode = 0;
    start_pulse(64'h3010);
    wait_ack(lat, d, e);
    tests++; if (lat !== 5 || d !== exp || e !== 1'b0) begin errors++; $display("FAIL rsthi_recover got lat=%0d data=%h err=%b want 5 %h 0", lat, d, e, exp); end
    idle(2);
  endtask

  initial begin
    sys_rst  = 1'b1;
    hm_start = 1'b0;
    hm_addr  = 64'd0;
    test_reset();
    test_basic_read();
    test_high_addr();
    test_timeout();
    test_bus_error();
    test_back_to_back();
    test_reset_in_hi();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/mpu_host_memory.md
Name: mpu_host_memory

Overview:
Responder end of the MPU host-memory (hm) interface. Accepts a 64-bit read request (hm_addr, hm_start) from the MPU execution unit and fetches the 8-byte word as two 32-bit Wishbone classic reads. Returns hm_data with a one-cycle hm_ack, plus hm_error on bus error or timeout. Sits between the MPU core and the system Wishbone bus; same clock domain.

Parameters:
TIMEOUT, 256, max cycles waited per Wishbone word for ack/err before abort (≥2)
TW, 9, width of the timeout counter; must hold TIMEOUT

Ports:
sys_clk  in  1  system clock; all logic on rising edge
sys_rst  in  1  synchronous, active-high reset
hm_addr  in  64  byte address of requested 64-bit word, from MPU
hm_start  in  1  request; rising edge (sampled) starts a read
hm_data  out  64  returned data; held until next completion
hm_ack  out  1  one-cycle completion pulse
hm_error  out  1  one-cycle pulse coincident with hm_ack on failure
busy  out  1  high from acceptance until the hm_ack cycle inclusive
wb_adr_o  out  32  Wishbone byte address
wb_dat_i  in  32  Wishbone read data
wb_sel_o  out  4  constant 4'hF
wb_cyc_o  out  1  bus cycle
wb_stb_o  out  1  strobe
wb_we_o  out  1  constant 0
wb_cti_o  out  3  constant 3'b000
wb_ack_i  in  1  slave ack
wb_err_i  in  1  slave error

Behaviour:
- Reset: state IDLE; hm_data=0, hm_ack=0, hm_error=0, busy=0, wb_cyc_o=0, wb_stb_o=0, wb_adr_o=0; start_q (previous hm_start)=0, so hm_start held high through reset is a valid request after reset. Reset mid-transfer drops cyc/stb at the next edge; the in-flight word is discarded and no hm_ack is issued.
- Edge detect: start_q<=hm_start every cycle; request = hm_start & ~start_q. Requests seen outside IDLE are dropped, not queued.
- States: IDLE, LO, HI, ACK.
- IDLE: on request, latch addr A = {hm_addr[31:3],3'b000}. If hm_addr[63:32]!=0, go to ACK with error and no bus cycle. Otherwise go to LO with wb_adr_o=A, cyc=stb=1, and the counter cleared.
- LO: on wb_ack_i, latch wb_dat_i into lo_q, set wb_adr_o=A+4, keep cyc/stb high, clear the counter, and go to HI. wb_err_i, or counter reaching TIMEOUT-1 with no ack, drops cyc/stb and goes to ACK with error. ack and err together count as err.
- HI: same rules. On ack, the result is {wb_dat_i, lo_q}, cyc/stb drop, and the state goes to ACK.
- ACK, one cycle: hm_ack=1. hm_data=result, or 64'hFFFF_FFFF_FFFF_FFFF on error, in which case hm_error=1. Next state IDLE. hm_data is registered on ACK entry and is stable until the next ACK.
- Latency: request sampled in cycle T, stb rises at T+1. If the slave acks k≥1 cycles after stb presentation, hm_ack is at T+2k+3 (k=1 gives T+5).
- Timeout: counter increments each cycle in LO/HI without ack/err, and aborts when count reaches TIMEOUT-1, i.e. TIMEOUT cycles of stb with no response.
- Address bits [2:0] are ignored. A+4 never carries past bit 31 because A is 8-byte aligned.

Optional Feature:
MPU_HM_BSWAP_EN. Defined: the result is byte-reversed across all 64 bits (big-endian view), applied before the hm_data register; the error value is unchanged. Undefined: little-endian, low word from A in hm_data[31:0].

Decomposition:
- Package mpu_hm_pkg: state encoding (IDLE/LO/HI/ACK, 2 bits), HM_ERR_DATA constant (all ones), WB_SEL_ALL, WB_CTI_CLASSIC.
- Sub-module mpu_hm_timeout: TW-bit counter with clear/enable inputs and an expired output, parameterised by TIMEOUT. Everything else lives in one always block plus the FSM.

Test Plan:
- Memory bytes 0x00..0x07 at 0x1000, hm_addr=0x1005, start pulse, slave k=1 -> wb_adr 0x1000 then 0x1004; hm_ack at T+5; hm_data=64'h0706050403020100 (BSWAP_EN: 64'h0001020304050607); hm_error=0.
- hm_addr=64'h1_0000_0000 -> no cyc; hm_ack at T+1 with hm_error=1; hm_data all ones.
- Slave never acks the HI word, TIMEOUT=16 -> stb on 0x2004 for exactly 16 cycles then drops; hm_ack+hm_error next cycle.
- wb_err_i on LO word -> cyc drops; hm_error=1; no access to A+4.
- hm_start held high across two completions -> exactly one transfer. Second rising edge during busy -> ignored. Rising edge after the ACK cycle -> served.
- sys_rst asserted while in HI -> next cycle cyc=stb=busy=0, hm_data=0, no hm_ack. Then a new request completes normally.
